// File: rtl/xform_seq_pkg.sv
// Shared types and reset geometry for the pass/invert frame sequencer.
package xform_seq_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    localparam int RST_PERIOD = 7;
    localparam int RST_PASS   = 5;

endpackage

// File: rtl/xform_lane.sv
// Registered pass/invert data lane; holds its value while disabled.
module xform_lane #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic             i_invert_en,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    // Output register: pass or invert the input on active beats, hold otherwise.
    always_ff @(posedge clk) begin
        if (i_clear) begin
            o_data <= {WIDTH{1'b0}};
        end else if (i_en) begin
            o_data <= i_invert_en ? ~i_data : i_data;
        end
    end

endmodule

// File: rtl/xform_sequencer.sv
// Frame sequencer: FSM, beat counter, pending/active geometry and frame counter
// driving a pass/invert lane.
module xform_sequencer
    import xform_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_pass,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] cct_input,
    output logic [WIDTH-1:0] cct_output,
    output logic             busy,
    output logic             invert_en,
    output logic             frame_start,
    output logic [7:0]       frame_count
);

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_act_period;
    logic [CNT_W-1:0] r_act_pass;
    logic [CNT_W-1:0] r_pend_period;
    logic [CNT_W-1:0] r_pend_pass;
    logic             r_pend_valid;
    logic [7:0]       r_frame_count;

    logic             w_busy;
    logic             w_last;
    logic             w_pass_beat;
    logic             w_apply;
    logic [CNT_W-1:0] w_count_nxt;

    assign w_busy      = (r_state != IDLE);
    assign w_last      = w_busy && (r_count == r_act_period);
    assign w_pass_beat = (r_count < r_act_pass);
    assign w_count_nxt = w_last ? {CNT_W{1'b0}} : (r_count + CNT_W'(1));
    // New geometry lands only between frames so a frame never changes shape.
    assign w_apply     = r_pend_valid && ((r_state == IDLE) || w_last);

    // Framing FSM and beat counter.
    always_ff @(posedge clk) begin
        if (clear) begin
            r_state <= IDLE;
            r_count <= {CNT_W{1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    r_count <= {CNT_W{1'b0}};
                    if (start) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_count <= w_count_nxt;
                    if (stop) begin
                        r_state <= STOPPING;
                    end
                end
                STOPPING: begin
                    if (start) begin
                        r_state <= RUN;
                        r_count <= w_count_nxt;
                    end else if (w_last) begin
                        r_state <= IDLE;
                        r_count <= {CNT_W{1'b0}};
                    end else begin
                        r_count <= w_count_nxt;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_count <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Config handshake: capture into pending, promote to active between frames.
    always_ff @(posedge clk) begin
        if (clear) begin
            r_act_period  <= CNT_W'(RST_PERIOD);
            r_act_pass    <= CNT_W'(RST_PASS);
            r_pend_period <= {CNT_W{1'b0}};
            r_pend_pass   <= {CNT_W{1'b0}};
            r_pend_valid  <= 1'b0;
        end else if (w_apply) begin
            r_act_period <= r_pend_period;
            r_act_pass   <= r_pend_pass;
            r_pend_valid <= 1'b0;
        end else if (cfg_valid && !r_pend_valid) begin
            r_pend_period <= cfg_period;
            r_pend_pass   <= cfg_pass;
            r_pend_valid  <= 1'b1;
        end
    end

    // Completed-frame counter, free-wrapping.
    always_ff @(posedge clk) begin
        if (clear) begin
            r_frame_count <= 8'd0;
        end else if (w_last) begin
            r_frame_count <= r_frame_count + 8'd1;
        end
    end

    xform_lane #(
        .WIDTH(WIDTH)
    ) u_lane (
        .clk         (clk),
        .i_clear     (clear),
        .i_en        (w_busy),
        .i_invert_en (!w_pass_beat),
        .i_data      (cct_input),
        .o_data      (cct_output)
    );

    assign cfg_ready   = !r_pend_valid;
    assign busy        = w_busy;
    assign invert_en   = w_busy && !w_pass_beat;
    assign frame_start = w_busy && (r_count == {CNT_W{1'b0}});
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_xform_sequencer.sv
// Self-checking bench for xform_sequencer: table-driven default frame plus
// hand-written multi-cycle sequences with an output scoreboard.
module tb_xform_sequencer;

    logic       clk;
    logic       clear;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [2:0] cfg_period;
    logic [2:0] cfg_pass;
    logic       start;
    logic       stop;
    logic [7:0] cct_input;
    logic [7:0] cct_output;
    logic       busy;
    logic       invert_en;
    logic       frame_start;
    logic [7:0] frame_count;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] exp_out;
        logic       exp_inv;
        logic       exp_fs;
    } vec_t;
    vec_t tbl[8];

    xform_sequencer dut (
        .clk         (clk),
        .clear       (clear),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_period  (cfg_period),
        .cfg_pass    (cfg_pass),
        .start       (start),
        .stop        (stop),
        .cct_input   (cct_input),
        .cct_output  (cct_output),
        .busy        (busy),
        .invert_en   (invert_en),
        .frame_start (frame_start),
        .frame_count (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One active beat: check beat flags, drive data, push expected output, compare after the edge.
    task automatic beat(input logic [7:0] din, input int cnt, input int pass, input string tag);
        logic [7:0] e;
        chk({tag, "_fs"}, frame_start, (cnt == 0) ? 1 : 0);
        chk({tag, "_inv"}, invert_en, (cnt < pass) ? 0 : 1);
        cct_input = din;
        exp_q.push_back((cnt < pass) ? din : ~din);
        @(negedge clk);
        e = exp_q.pop_front();
        chk({tag, "_out"}, cct_output, e);
    endtask

    task automatic do_clear();
        clear = 1'b1; cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic load_cfg(input logic [2:0] p, input logic [2:0] ps);
        chk("cfg_ready_pre", cfg_ready, 1);
        cfg_valid = 1'b1; cfg_period = p; cfg_pass = ps;
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("cfg_ready_low", cfg_ready, 0);
        @(negedge clk);
        chk("cfg_ready_back", cfg_ready, 1);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", busy, 1);
    endtask

    initial begin
        clear = 1'b0; cfg_valid = 1'b0; cfg_period = 3'd0; cfg_pass = 3'd0;
        start = 1'b0; stop = 1'b0; cct_input = 8'h00;
        for (int k = 0; k < 8; k++) begin
            tbl[k].exp_out = (k < 5) ? 8'hA5 : 8'h5A;
            tbl[k].exp_inv = (k < 5) ? 1'b0 : 1'b1;
            tbl[k].exp_fs  = (k == 0) ? 1'b1 : 1'b0;
        end
        @(negedge clk);

        // 1: reset state, then default 7/5 frames from the table
        do_clear();
        chk("rst_out", cct_output, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_ready", cfg_ready, 1);
        chk("rst_fc", frame_count, 0);
        chk("rst_inv", invert_en, 0);
        chk("rst_fs", frame_start, 0);
        cct_input = 8'hA5;
        do_start();
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 8; k++) begin
                logic [7:0] e;
                chk("t1_fs", frame_start, tbl[k].exp_fs);
                chk("t1_inv", invert_en, tbl[k].exp_inv);
                cct_input = 8'hA5;
                exp_q.push_back(tbl[k].exp_out);
                @(negedge clk);
                e = exp_q.pop_front();
                chk("t1_out", cct_output, e);
            end
        end
        chk("t1_fc", frame_count, 2);

        // 2: period 3 / pass 1 loaded while idle
        do_clear();
        load_cfg(3'd3, 3'd1);
        do_start();
        for (int k = 0; k < 8; k++) beat(8'h0F, k % 4, 1, "t2");
        chk("t2_fc", frame_count, 2);

        // 3: reconfigure mid-frame; takes effect on the next frame
        do_clear();
        do_start();
        for (int k = 0; k < 8; k++) begin
            if (k == 2) begin
                cfg_valid = 1'b1; cfg_period = 3'd5; cfg_pass = 3'd2;
            end
            beat(8'h3C, k, 5, "t3a");
            cfg_valid = 1'b0;
            if (k == 2) chk("t3_ready_low", cfg_ready, 0);
        end
        chk("t3_fc1", frame_count, 1);
        chk("t3_ready_back", cfg_ready, 1);
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 6; k++) beat(8'h3C, k, 2, "t3b");
            chk("t3_fc", frame_count, 2 + f);
        end

        // 4: stop mid-frame completes the frame; start while stopping resumes
        do_clear();
        do_start();
        for (int k = 0; k < 8; k++) begin
            stop = (k == 2);
            beat(8'hC3, k, 5, "t4a");
            stop = 1'b0;
            if (k < 7) chk("t4_busy_hold", busy, 1);
        end
        chk("t4_idle", busy, 0);
        chk("t4_fc", frame_count, 1);
        chk("t4_idle_fs", frame_start, 0);
        cct_input = 8'h11;
        @(negedge clk);
        chk("t4_hold_out", cct_output, 8'h3C);
        do_start();
        for (int k = 0; k < 8; k++) begin
            stop  = (k == 2);
            start = (k == 5);
            beat(8'h96, k, 5, "t4b");
            stop = 1'b0; start = 1'b0;
        end
        chk("t4_resume_busy", busy, 1);
        chk("t4_fc2", frame_count, 2);
        for (int k = 0; k < 8; k++) beat(8'h69, k, 5, "t4c");
        chk("t4_fc3", frame_count, 3);

        // 5: clear mid-frame with a pending config restores defaults
        do_clear();
        load_cfg(3'd6, 3'd6);
        do_start();
        for (int k = 0; k < 4; k++) beat(8'h33, k, 6, "t5a");
        chk("t5_pre_out", cct_output, 8'h33);
        clear = 1'b1; cfg_valid = 1'b1; cfg_period = 3'd2; cfg_pass = 3'd0;
        @(negedge clk);
        clear = 1'b0; cfg_valid = 1'b0;
        chk("t5_out", cct_output, 8'h00);
        chk("t5_busy", busy, 0);
        chk("t5_ready", cfg_ready, 1);
        chk("t5_fc", frame_count, 0);
        do_start();
        for (int k = 0; k < 8; k++) beat(8'hE1, k, 5, "t5b");
        chk("t5_fc_after", frame_count, 1);

        // 6: pass 0 (all invert) and pass 7 > period (all pass)
        do_clear();
        load_cfg(3'd3, 3'd0);
        do_start();
        for (int k = 0; k < 8; k++) beat(8'($urandom_range(0, 255)), k % 4, 0, "t6a");
        do_clear();
        load_cfg(3'd3, 3'd7);
        do_start();
        for (int k = 0; k < 8; k++) beat(8'($urandom_range(0, 255)), k % 4, 7, "t6b");
        chk("t6_fc", frame_count, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
